// File: rtl/conv_frame_ctrl.sv
// Frame-level sequencer for the conv chunk filter: tracks chunk position, gates conv.en.
// Optional CONV_FRAME_STATS_EN adds a per-frame filtered-beat counter (filt_cnt).
module conv_frame_ctrl #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned DIM    = 3,
    parameter int unsigned EN_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic        in_rdy,
    input  logic        in_sof,
    input  logic        cfg_filter_en,
    input  logic        cfg_border_pass,
    output logic        en,
    output logic        busy,
    output logic        frame_done,
    output logic        sync_err,
    output logic [15:0] frame_cnt
`ifdef CONV_FRAME_STATS_EN
    ,
    output logic [23:0] filt_cnt
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int R = int'(DIM / 2);
    localparam logic [CW-1:0] ColLast = CW'(WIDTH - 1);
    localparam logic [RW-1:0] RowLast = RW'(HEIGHT - 1);

    typedef enum logic {StIdle, StActive} state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic              filt_q, filt_d;
    logic              bp_q, bp_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q;
    logic [EN_LAT-1:0] en_pipe_q;

    logic          beat, start, pix, last, interior, en_beat, filt, bp;
    logic [RW-1:0] pr;
    logic [CW-1:0] pc;

`ifdef CONV_FRAME_STATS_EN
    logic [23:0] run_q, run_d, filt_cnt_q, filt_cnt_d, sum;
`endif

    always_comb begin
        beat  = in_vld & in_rdy;
        start = beat & in_sof;
        // A beat is a real pixel when it starts a frame or continues an active one.
        pix   = beat & (in_sof | (state_q == StActive));
        err_d = beat & (((state_q == StIdle) & ~in_sof) |
                        ((state_q == StActive) & in_sof & ((row_q != '0) | (col_q != '0))));

        pr   = start ? '0 : row_q;
        pc   = start ? '0 : col_q;
        filt = start ? cfg_filter_en : filt_q;
        bp   = start ? cfg_border_pass : bp_q;

        interior = (int'(pr) >= R) && (int'(pr) <= int'(HEIGHT) - 1 - R) &&
                   (int'(pc) >= R) && (int'(pc) <= int'(WIDTH) - 1 - R);
        en_beat  = pix & filt & (interior | ~bp);
        last     = (pr == RowLast) && (pc == ColLast);

        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        filt_d      = filt_q;
        bp_d        = bp_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;

        if (pix) begin
            filt_d = filt;
            bp_d   = bp;
            if (last) begin
                state_d     = StIdle;
                row_d       = '0;
                col_d       = '0;
                done_d      = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                state_d = StActive;
                if (pc == ColLast) begin
                    col_d = '0;
                    row_d = pr + RW'(1);
                end else begin
                    col_d = pc + CW'(1);
                    row_d = pr;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            filt_q      <= 1'b0;
            bp_q        <= 1'b0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            en_pipe_q   <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            filt_q       <= filt_d;
            bp_q         <= bp_d;
            frame_cnt_q  <= frame_cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= (state_d == StActive);
            en_pipe_q[0] <= en_beat;
            for (int i = 1; i < int'(EN_LAT); i++) begin
                en_pipe_q[i] <= en_pipe_q[i-1];
            end
        end
    end

`ifdef CONV_FRAME_STATS_EN
    always_comb begin
        run_d      = run_q;
        filt_cnt_d = filt_cnt_q;
        sum        = (start ? 24'd0 : run_q) + 24'(en_beat);
        if (pix) begin
            if (last) begin
                filt_cnt_d = sum;
                run_d      = '0;
            end else begin
                run_d = sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q      <= '0;
            filt_cnt_q <= '0;
        end else begin
            run_q      <= run_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign filt_cnt = filt_cnt_q;
`endif

    assign en         = en_pipe_q[EN_LAT-1];
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign sync_err   = err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
